fetch_ctrl: RTL and testbench

Sequencing controller for the instruction-fetch datapath (PC register, +4/branch/jump adders, next-PC muxes). It drives the PC register write enable and the next-PC select. It handshakes with a variable-latency instruction memory and holds the PC during decode stalls. It also defers branch/jump redirects that arrive while a fetch is in flight, and flags a memory timeout.

---
 rtl/fetch_ctrl_pkg.sv | 20 ++
 rtl/fetch_wait_timer.sv | 26 ++
 rtl/fetch_ctrl.sv | 105 ++++++++++
 tb/tb_fetch_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: state encodings and next-PC select codes shared by the fetch controller.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_REQ   = 2'd1,
        S_STALL = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_JMP = 2'b01;
    localparam logic [1:0] PC_SEL_BR  = 2'b10;

    // Branch outranks jump, matching the datapath mux order.
    function automatic logic [1:0] redir_sel(input logic br);
        return br ? PC_SEL_BR : PC_SEL_JMP;
    endfunction

endpackage

// File: rtl/fetch_wait_timer.sv
// fetch_wait_timer: shared counter for the reset hold and the memory timeout.
module fetch_wait_timer #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign o_tc = r_cnt == i_term;

endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer driving PC write enable and next-PC select,
// with memory handshake, decode-stall hold, deferred redirects and a sticky timeout.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int MAX_WAIT          = 16,
    parameter int CNT_W             = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_ready,
    input  logic       stall,
    input  logic       branch,
    input  logic       jmp,
    output logic       imem_req,
    output logic       pc_wr_en,
    output logic [1:0] pc_sel,
    output logic       inst_valid,
    output logic       redir_busy,
    output logic       fetch_err
);

    state_t r_state;
    logic   r_pend;
    logic   r_pend_br;

    logic             w_in_req;
    logic             w_in_stall;
    logic             w_rdy;
    logic             w_redir;
    logic             w_tc;
    logic             w_clr;
    logic             w_en;
    logic [CNT_W-1:0] w_term;

    assign w_in_req   = r_state == S_REQ;
    assign w_in_stall = r_state == S_STALL;
    assign w_rdy      = w_in_req & imem_ready;
    assign w_redir    = branch | jmp;

    // One counter serves both phases; the terminal value follows the state.
    assign w_term = (r_state == S_RST) ? CNT_W'(RESET_HOLD_CYCLES - 1) : CNT_W'(MAX_WAIT - 1);
    assign w_clr  = (r_state == S_RST && w_tc) | w_rdy | w_in_stall;
    assign w_en   = (r_state == S_RST) | w_in_req;

    fetch_wait_timer #(.CNT_W(CNT_W)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .i_term (w_term),
        .o_tc   (w_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_RST;
            r_pend    <= 1'b0;
            r_pend_br <= 1'b0;
        end else begin
            case (r_state)
                S_RST:
                    if (w_tc)
                        r_state <= S_REQ;
                S_REQ:
                    if (imem_ready) begin
                        r_pend <= 1'b0;
                        if (!r_pend && !w_redir && stall)
                            r_state <= S_STALL;
                    end else if (w_tc) begin
                        r_state <= S_ERR;
                    end else if (w_redir && !r_pend) begin
                        // Only the first redirect of an access counts; later ones are wrong-path.
                        r_pend    <= 1'b1;
                        r_pend_br <= branch;
                    end
                S_STALL:
                    if (w_redir || !stall)
                        r_state <= S_REQ;
                default: ;
            endcase
        end
    end

    always_comb begin
        imem_req   = w_in_req;
        fetch_err  = r_state == S_ERR;
        redir_busy = w_in_req & r_pend;
        inst_valid = 1'b0;
        pc_wr_en   = 1'b0;
        pc_sel     = PC_SEL_INC;
        if (w_rdy && r_pend) begin
            pc_wr_en = 1'b1;
            pc_sel   = redir_sel(r_pend_br);
        end else if ((w_rdy || w_in_stall) && w_redir) begin
            pc_wr_en = 1'b1;
            pc_sel   = redir_sel(branch);
        end else if (w_rdy || w_in_stall) begin
            inst_valid = 1'b1;
            pc_wr_en   = !stall;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed and random stimulus; a fetch-level reference model queues
// the expected outputs per cycle and an independent monitor compares them.
module tb_fetch_ctrl;

    localparam int RHC = 2;
    localparam int MW  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       imem_ready = 1'b0;
    logic       stall = 1'b0;
    logic       branch = 1'b0;
    logic       jmp = 1'b0;
    logic       imem_req;
    logic       pc_wr_en;
    logic [1:0] pc_sel;
    logic       inst_valid;
    logic       redir_busy;
    logic       fetch_err;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_HOLD_CYCLES(RHC), .MAX_WAIT(MW), .CNT_W(5)) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_ready (imem_ready),
        .stall      (stall),
        .branch     (branch),
        .jmp        (jmp),
        .imem_req   (imem_req),
        .pc_wr_en   (pc_wr_en),
        .pc_sel     (pc_sel),
        .inst_valid (inst_valid),
        .redir_busy (redir_busy),
        .fetch_err  (fetch_err)
    );

    typedef struct packed {
        logic       req;
        logic       wr;
        logic [1:0] sel;
        logic       iv;
        logic       busy;
        logic       err;
    } out_t;

    out_t exp_q[$];
    int   cyc_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    bit   started = 0;

    // Fetch-level model: boot countdown, an outstanding access with its wait time,
    // a held instruction during stall, and the deferred redirect target (0 none, 1 jmp, 2 br).
    int boot = 0;
    int waited = 0;
    int pend = 0;
    bit dead = 0;
    bit holding = 0;

    task automatic model(input logic r, rdy, st, br, jp, output out_t e);
        logic       redir;
        logic [1:0] rsel;
        e = '0;
        redir = br | jp;
        rsel = br ? 2'b10 : 2'b01;
        if (r) begin
            boot = 0; waited = 0; pend = 0; dead = 0; holding = 0;
        end else if (dead) begin
            e.err = 1'b1;
        end else if (boot < RHC) begin
            boot++;
        end else if (holding) begin
            if (redir) begin
                e.wr = 1'b1; e.sel = rsel; holding = 0;
            end else begin
                e.iv = 1'b1; e.wr = !st; holding = st;
            end
        end else begin
            e.req = 1'b1;
            e.busy = pend != 0;
            if (rdy) begin
                waited = 0;
                if (pend != 0) begin
                    e.wr = 1'b1; e.sel = 2'(pend); pend = 0;
                end else if (redir) begin
                    e.wr = 1'b1; e.sel = rsel;
                end else begin
                    e.iv = 1'b1; e.wr = !st; holding = st;
                end
            end else if (waited == MW - 1) begin
                dead = 1;
            end else begin
                waited++;
                if (pend == 0 && redir) pend = br ? 2 : 1;
            end
        end
    endtask

    // Inputs change 1 time unit after the rising edge, so reset lands between edges.
    task automatic step(input logic r, rdy, st, br, jp);
        out_t e;
        @(posedge clk);
        #1;
        reset = r; imem_ready = rdy; stall = st; branch = br; jmp = jp;
        model(r, rdy, st, br, jp, e);
        exp_q.push_back(e);
        cyc_q.push_back(cyc);
        cyc++;
        started = 1;
    endtask

    initial begin
        out_t a;
        out_t e;
        int   c;
        forever begin
            @(negedge clk);
            if (started) begin
                a = {imem_req, pc_wr_en, pc_sel, inst_valid, redir_busy, fetch_err};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL no_expect: DUT req=%b wr=%b sel=%b iv=%b busy=%b err=%b with empty queue",
                             a.req, a.wr, a.sel, a.iv, a.busy, a.err);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    if (a !== e) begin
                        n_bad++;
                        $display("FAIL cycle%0d outputs: got req=%b wr=%b sel=%b iv=%b busy=%b err=%b, want req=%b wr=%b sel=%b iv=%b busy=%b err=%b",
                                 c, a.req, a.wr, a.sel, a.iv, a.busy, a.err,
                                 e.req, e.wr, e.sel, e.iv, e.busy, e.err);
                    end
                end
            end
        end
    end

    initial begin
        int p;
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // reset release, hold, first fetch
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        // stall for three cycles then release
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        // branch during an access is deferred
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // simultaneous branch and jump on a ready cycle
        step(0, 1, 0, 1, 1);
        // redirect beats stall while holding
        step(0, 1, 1, 0, 0);
        step(0, 0, 1, 0, 1);
        // timeout, then everything ignored
        repeat (18) step(0, 0, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 1, 0, 1);
        step(1, 0, 0, 0, 0);
        // async reset mid-wait drops the pending jump
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            p = (i / 500) % 3 + 1;
            if ($urandom_range(0, 299) == 0) begin
                step(1, $urandom_range(0, 1) == 0, 0, 0, 0);
                step(0, 0, 0, 0, 0);
            end else begin
                step(0, $urandom_range(0, p) == 0, $urandom_range(0, 2) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
            end
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
